// File: rtl/timing_sequencer_if.sv
// Bundle between the decoder/predecode side and the T-state sequencer.
// The master drives the sequencing requests and the slave returns the timing strobes.
interface timing_sequencer_if #(
  parameter int NUM_T   = 7,
  parameter int STALL_W = 8
);
  logic               RDY;
  logic               TRES;
  logic               IRQ;
  logic               I_FLAG;
  logic               NMI;
  logic [NUM_T-1:0]   T;
  logic               T0;
  logic               T1;
  logic               SYNC;
  logic               FORCE_BRK;
  logic               RST_SEQ;
  logic               NMI_SEQ;
  logic [STALL_W-1:0] STALL_CNT;
  logic               OVF;

  modport master (
    output RDY, TRES, IRQ, I_FLAG, NMI,
    input  T, T0, T1, SYNC, FORCE_BRK, RST_SEQ, NMI_SEQ, STALL_CNT, OVF
  );

  modport slave (
    input  RDY, TRES, IRQ, I_FLAG, NMI,
    output T, T0, T1, SYNC, FORCE_BRK, RST_SEQ, NMI_SEQ, STALL_CNT, OVF
  );
endinterface

// File: rtl/timing_sequencer.sv
// One-hot T-state generator with RDY stalls, early termination, interrupt
// latching into a forced BRK sequence, and sticky overrun detection.
module timing_sequencer #(
  parameter int NUM_T   = 7,
  parameter int STALL_W = 8
) (
  input  logic              PHI0,
  input  logic              RES,
  timing_sequencer_if.slave bus
);
  localparam logic [STALL_W-1:0] STALL_MAX = '1;
  localparam logic [NUM_T-1:0]   T_RESET   = {{(NUM_T-2){1'b0}}, 2'b10};

  logic [NUM_T-1:0]   t_reg;
  logic [NUM_T-1:0]   t_next;
  logic               force_brk_reg;
  logic               rst_seq_reg;
  logic               nmi_seq_reg;
  logic [STALL_W-1:0] stall_reg;
  logic               ovf_reg;
  logic               nmi_pend_reg;
  logic               nmi_q_reg;
  logic               nmi_edge;

  assign nmi_edge = bus.NMI & ~nmi_q_reg;

  // T0 always advances to T1; middle states either step or collapse to T0 on TRES.
  assign t_next[0] = t_reg[NUM_T-1] | (bus.TRES & (|t_reg[NUM_T-2:1]));

  generate
    for (genvar gi = 1; gi < NUM_T; gi++) begin : g_adv
      if (gi == 1) begin : g_first
        assign t_next[gi] = t_reg[0];
      end else begin : g_rest
        assign t_next[gi] = t_reg[gi-1] & ~bus.TRES;
      end
    end
  endgenerate

  always_ff @(posedge PHI0 or posedge RES) begin
    if (RES) begin
      t_reg         <= T_RESET;
      force_brk_reg <= 1'b1;
      rst_seq_reg   <= 1'b1;
      nmi_seq_reg   <= 1'b0;
      stall_reg     <= '0;
      ovf_reg       <= 1'b0;
      nmi_pend_reg  <= 1'b0;
      nmi_q_reg     <= 1'b0;
    end else begin
      nmi_q_reg <= bus.NMI;
      if (!bus.RDY) begin
        if (stall_reg != STALL_MAX) begin
          stall_reg <= stall_reg + 1'b1;
        end
        if (nmi_edge) begin
          nmi_pend_reg <= 1'b1;
        end
      end else begin
        t_reg <= t_next;
        if (t_reg[NUM_T-1] && !bus.TRES) begin
          ovf_reg <= 1'b1;
        end
        if (t_reg[0]) begin
          // Instruction boundary: an edge arriving right now counts as pending.
          stall_reg    <= '0;
          nmi_pend_reg <= 1'b0;
          if (nmi_pend_reg || nmi_edge) begin
            force_brk_reg <= 1'b1;
            nmi_seq_reg   <= 1'b1;
            rst_seq_reg   <= 1'b0;
          end else if (bus.IRQ && !bus.I_FLAG) begin
            force_brk_reg <= 1'b1;
            nmi_seq_reg   <= 1'b0;
            rst_seq_reg   <= 1'b0;
          end else begin
            force_brk_reg <= 1'b0;
            nmi_seq_reg   <= 1'b0;
            rst_seq_reg   <= 1'b0;
          end
        end else if (nmi_edge) begin
          nmi_pend_reg <= 1'b1;
        end
      end
    end
  end

  assign bus.T         = t_reg;
  assign bus.T0        = t_reg[0];
  assign bus.T1        = t_reg[1];
  assign bus.SYNC      = t_reg[1] & bus.RDY;
  assign bus.FORCE_BRK = force_brk_reg;
  assign bus.RST_SEQ   = rst_seq_reg;
  assign bus.NMI_SEQ   = nmi_seq_reg;
  assign bus.STALL_CNT = stall_reg;
  assign bus.OVF       = ovf_reg;
endmodule

// File: tb/tb_timing_sequencer.sv
// Directed and randomized check of timing_sequencer against an integer-level model.
// Two instances share stimulus so both the wide and a 2-bit stall counter are exercised.
module tb_timing_sequencer;
  localparam int NT = 7;

  logic clk;
  logic res;
  logic rdy, tres, irq, iflag, nmi;

  int total = 0;
  int bad   = 0;
  int nstep = 0;

  // reference model state: T index as an integer, stall count unsaturated
  int m_t;
  int m_stall;
  bit m_fb, m_rst, m_nmi, m_ovf, m_pend, m_nmiq;

  timing_sequencer_if #(.NUM_T(NT), .STALL_W(8)) bus_a ();
  timing_sequencer_if #(.NUM_T(NT), .STALL_W(2)) bus_b ();

  assign bus_a.RDY = rdy;  assign bus_a.TRES = tres; assign bus_a.IRQ = irq;
  assign bus_a.I_FLAG = iflag; assign bus_a.NMI = nmi;
  assign bus_b.RDY = rdy;  assign bus_b.TRES = tres; assign bus_b.IRQ = irq;
  assign bus_b.I_FLAG = iflag; assign bus_b.NMI = nmi;

  timing_sequencer #(.NUM_T(NT), .STALL_W(8)) dut_a (.PHI0(clk), .RES(res), .bus(bus_a));
  timing_sequencer #(.NUM_T(NT), .STALL_W(2)) dut_b (.PHI0(clk), .RES(res), .bus(bus_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_t = 1; m_stall = 0;
    m_fb = 1; m_rst = 1; m_nmi = 0; m_ovf = 0; m_pend = 0; m_nmiq = 0;
  endtask

  // advance the model by one PHI0 edge using the inputs currently applied
  task automatic model_edge();
    bit rise;
    rise = nmi && !m_nmiq;
    m_nmiq = nmi;
    if (!rdy) begin
      m_stall++;
      if (rise) m_pend = 1;
    end else if (m_t == 0) begin
      if (m_pend || rise) begin
        m_fb = 1; m_nmi = 1; m_rst = 0;
      end else if (irq && !iflag) begin
        m_fb = 1; m_nmi = 0; m_rst = 0;
      end else begin
        m_fb = 0; m_nmi = 0; m_rst = 0;
      end
      m_pend = 0; m_stall = 0; m_t = 1;
    end else begin
      if (rise) m_pend = 1;
      if (m_t == NT - 1) begin
        if (!tres) m_ovf = 1;
        m_t = 0;
      end else if (tres) begin
        m_t = 0;
      end else begin
        m_t = m_t + 1;
      end
    end
  endtask

  task automatic check_all(input string tag);
    int sa, sb;
    sa = (m_stall > 255) ? 255 : m_stall;
    sb = (m_stall > 3) ? 3 : m_stall;
    chk({tag, ".T"},       32'(bus_a.T), 32'(1) << m_t);
    chk({tag, ".onehot"},  32'($onehot(bus_a.T)), 32'(1));
    chk({tag, ".T0"},      32'(bus_a.T0), 32'(m_t == 0));
    chk({tag, ".T1"},      32'(bus_a.T1), 32'(m_t == 1));
    chk({tag, ".SYNC"},    32'(bus_a.SYNC), 32'((m_t == 1) && rdy));
    chk({tag, ".FBRK"},    32'(bus_a.FORCE_BRK), 32'(m_fb));
    chk({tag, ".RSTSEQ"},  32'(bus_a.RST_SEQ), 32'(m_rst));
    chk({tag, ".NMISEQ"},  32'(bus_a.NMI_SEQ), 32'(m_nmi));
    chk({tag, ".OVF"},     32'(bus_a.OVF), 32'(m_ovf));
    chk({tag, ".STALL8"},  32'(bus_a.STALL_CNT), 32'(sa));
    chk({tag, ".STALL2"},  32'(bus_b.STALL_CNT), 32'(sb));
    chk({tag, ".T_b"},     32'(bus_b.T), 32'(1) << m_t);
  endtask

  task automatic step(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    nstep++;
    $display("step %0d %s rdy=%0b tres=%0b irq=%0b if=%0b nmi=%0b -> T=%b fb=%0b rs=%0b ns=%0b st=%0d ovf=%0b",
             nstep, tag, rdy, tres, irq, iflag, nmi, bus_a.T, bus_a.FORCE_BRK,
             bus_a.RST_SEQ, bus_a.NMI_SEQ, bus_a.STALL_CNT, bus_a.OVF);
    check_all(tag);
  endtask

  // asynchronous reset asserted between edges, held across one edge
  task automatic rst_pulse();
    res = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    @(posedge clk);
    #1;
    check_all("rst_hold");
    res = 1'b0;
  endtask

  initial begin
    res = 1'b1; rdy = 1'b1; tres = 1'b0; irq = 1'b0; iflag = 1'b0; nmi = 1'b0;
    model_reset();
    #12;
    check_all("reset");
    @(posedge clk);
    #1;
    check_all("reset2");
    res = 1'b0;

    // TRES in T2: T1,T2,T0,T1, brk flags drop after leaving T0
    step("t1_t2");
    tres = 1'b1; step("tres_t2");
    tres = 1'b0; step("t0_t1");

    // no TRES: run through T6 into overrun, OVF stays set
    for (int i = 0; i < 7; i++) step("ovf_run");
    for (int i = 0; i < 3; i++) step("ovf_keep");

    // move to T1 then stall three cycles in T3
    while (m_t != 1) step("align");
    step("to_t2"); step("to_t3");
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) step("stall_t3");
    rdy = 1'b1; tres = 1'b1; step("tres_t3");
    tres = 1'b0; step("stall_clr");

    // long stall in T1: SYNC low, 2-bit counter saturates
    rdy = 1'b0;
    for (int i = 0; i < 6; i++) step("stall_sat");
    rdy = 1'b1;

    // NMI rising edge in T2 with unmasked IRQ at boundary: NMI wins, then IRQ
    step("to_t2n");
    nmi = 1'b1; step("nmi_t2");
    irq = 1'b1; iflag = 1'b0; tres = 1'b1; step("to_t0n");
    tres = 1'b0; step("nmi_take");
    nmi = 1'b0; step("n_t2");
    tres = 1'b1; step("n_t0");
    tres = 1'b0; step("irq_take");

    // masked IRQ, then reset mid-T4
    iflag = 1'b1; step("m_t2");
    tres = 1'b1; step("m_t0");
    tres = 1'b0; step("irq_masked");
    step("m_t2b"); step("m_t3"); step("m_t4");
    rst_pulse();

    // NMI edge on the boundary edge itself
    irq = 1'b0;
    tres = 1'b1; step("b_t0");
    tres = 1'b0; nmi = 1'b1; step("nmi_bound");
    nmi = 1'b0;

    // NMI edge during a stall is kept
    step("s_t2");
    rdy = 1'b0; nmi = 1'b1; step("nmi_stall");
    nmi = 1'b0; step("stall2");
    rdy = 1'b1; tres = 1'b1; step("s_t0");
    tres = 1'b1; step("tres_in_t0");
    tres = 1'b0;

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        rst_pulse();
      end else begin
        rdy   = ($urandom_range(0, 9) < 8);
        tres  = ($urandom_range(0, 3) == 0);
        irq   = ($urandom_range(0, 2) == 0);
        iflag = $urandom_range(0, 1) == 1;
        if ($urandom_range(0, 9) == 0) nmi = ~nmi;
        step("rand");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
